store_buffer: RTL and testbench

//  Write-side RAM path: accepts store requests from the MEM stage, converts
//  (addr, data, mem_sel) into word-aligned address, lane-shifted data and byte

---
 rtl/store_buffer_pkg.sv | 32 +++
 rtl/store_fifo.sv | 73 +++++++
 rtl/store_buffer.sv | 155 +++++++++++++++
 tb/tb_store_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer write path.
// Selector encodings are shared with the load path in writeback.
// Optional feature macro: STORE_MISALIGN_EXC_EN (consumed by store_buffer).
package store_buffer_pkg;

    localparam logic [3:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [3:0] MEM_SEL_HALF = 4'b0011;
    localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

    // One queued RAM write: word address, byte enables, lane-shifted data.
    typedef struct packed {
        logic [29:0] word_addr;
        logic [3:0]  be;
        logic [31:0] data;
    } sb_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } drain_state_t;

    // A store is legal when its selector is known and its offset is naturally aligned.
    function automatic logic store_is_legal(input logic [3:0] sel, input logic [1:0] off);
        case (sel)
            MEM_SEL_BYTE: return 1'b1;
            MEM_SEL_HALF: return !off[0];
            MEM_SEL_WORD: return (off == 2'b00);
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Purpose: circular store queue with a parallel word-address compare over live entries.
// Latency: a push is visible at head/count the cycle after it is written.
// Backpressure: full is exported; caller must not push when full nor pop when empty.
module store_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output sb_entry_t        head,
    output sb_entry_t        second,
    input  logic [29:0]      cmp_addr,
    output logic             match
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W-1:0] wr_next;
    sb_entry_t        mem [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    assign rd_next = rd_ptr + PTR_W'(1);
    assign wr_next = wr_ptr + PTR_W'(1);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign second  = mem[rd_next];

    // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_next;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Compare every live slot (distance from head below count) against the lookup address.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count) && (mem[i].word_addr == cmp_addr)) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Purpose: formats MEM-stage stores into RAM writes, queues them, drains in order, flags load hazards.
// Latency: store accepted in cycle N drives ram_en in cycle N+1; load_hazard is combinational.
// Backpressure: store_ready = !full (no bypass of a same-cycle pop); head held until ram_ready.
// Optional macro STORE_MISALIGN_EXC_EN reports rejected stores on store_misalign/misalign_addr.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        store_valid,
    output logic        store_ready,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    input  logic [3:0]  store_sel,
    input  logic        load_check_en,
    input  logic [31:0] load_check_addr,
    output logic        load_hazard,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic        ram_ready,
    output logic        empty,
    output logic        store_misalign,
    output logic [31:0] misalign_addr
);

    logic [1:0]     off;
    logic           legal;
    logic           accept;
    logic           push;
    logic           pop;
    sb_entry_t      push_entry;
    sb_entry_t      head;
    sb_entry_t      second;
    logic           fifo_full;
    logic           fifo_empty;
    logic [PTR_W:0] fifo_count;
    logic           fifo_match;
    drain_state_t   state;
    logic           load_vld;
    sb_entry_t      load_entry;
    logic           unused_load_lsb;

    // Formatter: lane-shift data and enables by the byte offset.
    assign off                  = store_addr[1:0];
    assign legal                = store_is_legal(store_sel, off);
    assign store_ready          = !fifo_full;
    assign accept               = store_valid && store_ready;
    assign push                 = accept && legal;
    assign push_entry.word_addr = store_addr[31:2];
    assign push_entry.be        = store_sel << off;
    assign push_entry.data      = store_data << {off, 3'b000};

    assign pop             = (state == ST_ISSUE) && ram_ready;
    assign load_hazard     = load_check_en && fifo_match;
    assign empty           = fifo_empty;
    assign unused_load_lsb = ^load_check_addr[1:0];

    store_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head       (head),
        .second     (second),
        .cmp_addr   (load_check_addr[31:2]),
        .match      (fifo_match)
    );

    // Pick the entry to present next: the current queue contents, or a store arriving this cycle.
    always_comb begin
        load_vld   = 1'b0;
        load_entry = push_entry;
        if (state == ST_IDLE) begin
            if (!fifo_empty) begin
                load_vld   = 1'b1;
                load_entry = head;
            end else if (push) begin
                load_vld = 1'b1;
            end
        end else if (ram_ready) begin
            if (fifo_count > (PTR_W+1)'(1)) begin
                load_vld   = 1'b1;
                load_entry = second;
            end else if (push) begin
                load_vld = 1'b1;
            end
        end
    end

    // Drain FSM with registered RAM outputs, held stable while ram_ready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            ram_en         <= 1'b0;
            ram_write_en   <= '0;
            ram_addr       <= '0;
            ram_write_data <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ISSUE: begin
                    if ((state == ST_IDLE) || ram_ready) begin
                        if (load_vld) begin
                            state          <= ST_ISSUE;
                            ram_en         <= 1'b1;
                            ram_write_en   <= load_entry.be;
                            ram_addr       <= {load_entry.word_addr, 2'b00};
                            ram_write_data <= load_entry.data;
                        end else begin
                            state          <= ST_IDLE;
                            ram_en         <= 1'b0;
                            ram_write_en   <= '0;
                            ram_addr       <= '0;
                            ram_write_data <= '0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ram_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef STORE_MISALIGN_EXC_EN
    // One-cycle pulse and captured address for each accepted-but-rejected store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_misalign <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            store_misalign <= accept && !legal;
            if (accept && !legal) begin
                misalign_addr <= store_addr;
            end
        end
    end
`else
    assign store_misalign = 1'b0;
    assign misalign_addr  = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: vector table for formatting, hand sequences for
// backpressure, hazards, push/pop overlap with wrap, and asynchronous reset mid-drain.
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        store_valid;
    logic        store_ready;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic [3:0]  store_sel;
    logic        load_check_en;
    logic [31:0] load_check_addr;
    logic        load_hazard;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        ram_ready;
    logic        empty;
    logic        store_misalign;
    logic [31:0] misalign_addr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        en;
        logic [3:0]  be;
        logic [31:0] raddr;
        logic [31:0] rdata;
        logic        mis;
    } vec_t;

    vec_t vecs [9];

    store_buffer #(
        .DEPTH (4),
        .PTR_W (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .store_valid     (store_valid),
        .store_ready     (store_ready),
        .store_addr      (store_addr),
        .store_data      (store_data),
        .store_sel       (store_sel),
        .load_check_en   (load_check_en),
        .load_check_addr (load_check_addr),
        .load_hazard     (load_hazard),
        .ram_en          (ram_en),
        .ram_write_en    (ram_write_en),
        .ram_addr        (ram_addr),
        .ram_write_data  (ram_write_data),
        .ram_ready       (ram_ready),
        .empty           (empty),
        .store_misalign  (store_misalign),
        .misalign_addr   (misalign_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before limit");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string name, input logic [31:0] a, input logic [31:0] d);
        check({name, "_en"}, ram_en, 1);
        check({name, "_be"}, ram_write_en, 4'hF);
        check({name, "_addr"}, ram_addr, a);
        check({name, "_data"}, ram_write_data, d);
    endtask

    initial begin
        logic [31:0] last_mis;
        int          rd;
        logic        sent;

        vecs[0] = '{32'h0000_1003, 32'h0000_00A5, 4'b0001, 1'b1, 4'b1000, 32'h0000_1000, 32'hA500_0000, 1'b0};
        vecs[1] = '{32'h0000_2002, 32'h0000_BEEF, 4'b0011, 1'b1, 4'b1100, 32'h0000_2000, 32'hBEEF_0000, 1'b0};
        vecs[2] = '{32'h0000_2001, 32'h0000_BEEF, 4'b0011, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 1'b1, 4'b1111, 32'h0000_4000, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{32'h0000_4002, 32'hDEAD_BEEF, 4'b1111, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_5000, 32'h0000_003C, 4'b0001, 1'b1, 4'b0001, 32'h0000_5000, 32'h0000_003C, 1'b0};
        vecs[6] = '{32'h0000_6000, 32'h0000_1111, 4'b0101, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'h0000_7000, 32'h0000_1234, 4'b0011, 1'b1, 4'b0011, 32'h0000_7000, 32'h0000_1234, 1'b0};
        vecs[8] = '{32'h0000_8001, 32'h0000_0077, 4'b0001, 1'b1, 4'b0010, 32'h0000_8000, 32'h0000_7700, 1'b0};

        rst = 1'b1;
        store_valid = 1'b0;
        store_addr = '0;
        store_data = '0;
        store_sel = '0;
        load_check_en = 1'b0;
        load_check_addr = '0;
        ram_ready = 1'b0;
        last_mis = '0;

        // Reset state
        #2;
        check("rst_store_ready", store_ready, 1);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_write_en", ram_write_en, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_write_data", ram_write_data, 0);
        check("rst_load_hazard", load_hazard, 0);
        check("rst_empty", empty, 1);
        check("rst_store_misalign", store_misalign, 0);
        check("rst_misalign_addr", misalign_addr, 0);
        step();
        rst = 1'b0;
        step();

        // Formatting table, one store at a time with ram_ready held high
        for (int i = 0; i < 9; i++) begin
            store_valid = 1'b1;
            store_addr  = vecs[i].addr;
            store_data  = vecs[i].data;
            store_sel   = vecs[i].sel;
            ram_ready   = 1'b1;
            check($sformatf("vec%0d_ready", i), store_ready, 1);
            step();
            store_valid = 1'b0;
`ifdef STORE_MISALIGN_EXC_EN
            if (vecs[i].mis) last_mis = vecs[i].addr;
            check($sformatf("vec%0d_misalign", i), store_misalign, vecs[i].mis);
`else
            check($sformatf("vec%0d_misalign", i), store_misalign, 0);
`endif
            check($sformatf("vec%0d_misalign_addr", i), misalign_addr, last_mis);
            check($sformatf("vec%0d_en", i), ram_en, vecs[i].en);
            check($sformatf("vec%0d_be", i), ram_write_en, vecs[i].be);
            check($sformatf("vec%0d_addr", i), ram_addr, vecs[i].raddr);
            check($sformatf("vec%0d_data", i), ram_write_data, vecs[i].rdata);
            step();
            check($sformatf("vec%0d_done_en", i), ram_en, 0);
            check($sformatf("vec%0d_done_empty", i), empty, 1);
            check($sformatf("vec%0d_pulse_end", i), store_misalign, 0);
        end

        // Five back-to-back word stores against a stalled RAM
        ram_ready = 1'b0;
        store_sel = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            store_valid = 1'b1;
            store_addr  = 32'h100 + 32'(4 * k);
            store_data  = 32'h1111_1111 * 32'(k + 1);
            check($sformatf("fill%0d_ready", k), store_ready, 1);
            step();
        end
        store_addr = 32'h110;
        store_data = 32'h5555_5555;
        check("full_ready_low", store_ready, 0);
        check("full_not_empty", empty, 0);
        expect_word("full_hold0", 32'h100, 32'h1111_1111);
        step();
        check("full_ready_still_low", store_ready, 0);
        expect_word("full_hold1", 32'h100, 32'h1111_1111);
        ram_ready = 1'b1;
        sent = 1'b0;
        for (int w = 0; w < 5; w++) begin
            if (sent) store_valid = 1'b0;
            else if (store_ready) sent = 1'b1;
            expect_word($sformatf("drain%0d", w), 32'h100 + 32'(4 * w), 32'h1111_1111 * 32'(w + 1));
            step();
        end
        store_valid = 1'b0;
        check("drain_empty", empty, 1);
        check("drain_ram_en_low", ram_en, 0);

        // Load hazard against a buffered word
        ram_ready = 1'b0;
        store_valid = 1'b1;
        store_addr = 32'h3000;
        store_data = 32'h0BAD_F00D;
        load_check_en = 1'b1;
        load_check_addr = 32'h3000;
        #1;
        check("haz_same_cycle_push", load_hazard, 0);
        step();
        store_valid = 1'b0;
        load_check_addr = 32'h3002;
        #1;
        check("haz_hit_3002", load_hazard, 1);
        load_check_addr = 32'h3004;
        #1;
        check("haz_miss_3004", load_hazard, 0);
        load_check_en = 1'b0;
        load_check_addr = 32'h3000;
        #1;
        check("haz_disabled", load_hazard, 0);
        load_check_en = 1'b1;
        ram_ready = 1'b1;
        step();
        ram_ready = 1'b0;
        check("haz_retired", load_hazard, 0);
        check("haz_retired_empty", empty, 1);
        load_check_en = 1'b0;

        // Steady push-while-pop at two entries; twelve stores wrap the pointers three times
        store_sel = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            store_valid = 1'b1;
            store_addr  = 32'hA00 + 32'(4 * k);
            store_data  = 32'hC0DE_0000 + 32'(k);
            step();
        end
        rd = 0;
        ram_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            expect_word($sformatf("ovl%0d", rd), 32'hA00 + 32'(4 * rd), 32'hC0DE_0000 + 32'(rd));
            rd++;
            store_valid = 1'b1;
            store_addr  = 32'hA00 + 32'(4 * (j + 2));
            store_data  = 32'hC0DE_0000 + 32'(j + 2);
            check($sformatf("ovl%0d_ready", j), store_ready, 1);
            check($sformatf("ovl%0d_not_empty", j), empty, 0);
            step();
        end
        store_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            expect_word($sformatf("ovl%0d", rd), 32'hA00 + 32'(4 * rd), 32'hC0DE_0000 + 32'(rd));
            rd++;
            step();
        end
        check("ovl_empty", empty, 1);
        check("ovl_ram_en_low", ram_en, 0);

        // Asynchronous reset while issuing with three entries queued
        ram_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            store_valid = 1'b1;
            store_addr  = 32'hE00 + 32'(4 * k);
            store_data  = 32'hE000_0000 + 32'(k);
            step();
        end
        store_valid = 1'b0;
        expect_word("arst_pre", 32'hE00, 32'hE000_0000);
        rst = 1'b1;
        #1;
        check("arst_ram_en", ram_en, 0);
        check("arst_empty", empty, 1);
        check("arst_ready", store_ready, 1);
        check("arst_ram_addr", ram_addr, 0);
        step();
        rst = 1'b0;
        ram_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("arst_after%0d_en", k), ram_en, 0);
            check($sformatf("arst_after%0d_empty", k), empty, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
